// File: rtl/nw_pkg.sv
// Shared types and helpers for the Needleman-Wunsch score RAM writer.
// Default geometry, score type, FSM states and address-width helper.
package nw_pkg;

  localparam int N_DEF   = 5;
  localparam int M_DEF   = 5;
  localparam int W_DEF   = 9;
  localparam int GAP_DEF = -2;

  typedef logic signed [W_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT_ROW,
    S_INIT_COL,
    S_READY
  } state_e;

  function automatic int addr_w(input int n, input int m);
    return $clog2((n + 1) * (m + 1));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/nw_border_seq.sv
// Border-cell generator: walks row 0 then column 0, presenting the next
// (addr, data) pair; data grows by GAP per step from an accumulator.
module nw_border_seq #(
  parameter int N   = 5,
  parameter int M   = 5,
  parameter int W   = 9,
  parameter int GAP = -2,
  parameter int AW  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_i,
  output logic [AW-1:0]       addr_o,
  output logic signed [W-1:0] data_o,
  output logic                row_end_o,
  output logic                last_o
);

  localparam int KW = $clog2(((N > M) ? N : M) + 1);
  localparam logic [KW-1:0]       K_N        = KW'(N);
  localparam logic [KW-1:0]       K_M        = KW'(M);
  localparam logic [AW-1:0]       ROW_STRIDE = AW'(M + 1);
  localparam logic signed [W-1:0] GAP_S      = W'(GAP);

  logic                col_q, col_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [AW-1:0]       addr_q, addr_d;

  assign row_end_o = !col_q && (k_q == K_M);
  assign last_o    = col_q && (k_q == K_N);
  assign addr_o    = addr_q;
  assign data_o    = acc_q;

  // Column phase starts at k=1 so the corner cell (0,0) is emitted only once.
  always_comb begin
    col_d  = col_q;
    k_d    = k_q;
    acc_d  = acc_q;
    addr_d = addr_q;
    if (step_i) begin
      if (last_o) begin
        col_d  = 1'b0;
        k_d    = '0;
        acc_d  = '0;
        addr_d = '0;
      end else if (row_end_o) begin
        col_d  = 1'b1;
        k_d    = KW'(1);
        acc_d  = GAP_S;
        addr_d = ROW_STRIDE;
      end else begin
        k_d    = k_q + KW'(1);
        acc_d  = acc_q + GAP_S;
        addr_d = addr_q + (col_q ? ROW_STRIDE : AW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= 1'b0;
      k_q    <= '0;
      acc_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/score_ram_writer.sv
// Single write port of the NW score RAM: self-sequenced border init, then
// one registered write per accepted DP cell insert.
module score_ram_writer
  import nw_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int M   = M_DEF,
  parameter  int W   = W_DEF,
  parameter  int GAP = GAP_DEF,
  localparam int AW  = addr_w(N, M),
  localparam int IW  = $clog2(N + 1),
  localparam int JW  = $clog2(M + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_init,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic [IW-1:0]       ins_i,
  input  logic [JW-1:0]       ins_j,
  input  logic signed [W-1:0] ins_score,
  output logic                we,
  output logic [AW-1:0]       addr,
  output logic signed [W-1:0] data,
  output logic                init_done,
  output logic                busy,
  output logic                err
);

  if ((N + M) * iabs(GAP) > 2 ** (W - 1) - 1) begin : g_width_check
    $error("score_ram_writer: (N+M)*|GAP| does not fit in W signed bits");
  end

  localparam logic [IW-1:0] I_MAX      = IW'(N);
  localparam logic [JW-1:0] J_MAX      = JW'(M);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(M + 1);

  state_e              state_q, state_d;
  logic                in_init, start_go, step, accept, in_range;
  logic                seq_row_end, seq_last;
  logic [AW-1:0]       seq_addr, ins_addr;
  logic signed [W-1:0] seq_data;
  logic                we_q, we_d, last_q, last_d, row_end_q, row_end_d, err_q, err_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic signed [W-1:0] data_q, data_d;

  nw_border_seq #(
    .N(N), .M(M), .W(W), .GAP(GAP), .AW(AW)
  ) u_border_seq (
    .clk      (clk),
    .rst      (rst),
    .step_i   (step),
    .addr_o   (seq_addr),
    .data_o   (seq_data),
    .row_end_o(seq_row_end),
    .last_o   (seq_last)
  );

  // The FSM state tracks the write currently on the output register, so
  // busy covers exactly the init write cycles.
  assign in_init  = (state_q == S_INIT_ROW) || (state_q == S_INIT_COL);
  assign start_go = start_init && ((state_q == S_IDLE) || (state_q == S_READY));
  assign step     = start_go || (in_init && !last_q);
  assign accept   = ins_valid && ins_ready;
  assign in_range = (ins_i != '0) && (ins_j != '0) && (ins_i <= I_MAX) && (ins_j <= J_MAX);
  assign ins_addr = AW'(ins_i) * ROW_STRIDE + AW'(ins_j);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_init)  state_d = S_INIT_ROW;
      S_INIT_ROW: if (row_end_q)   state_d = S_INIT_COL;
      S_INIT_COL: if (last_q)      state_d = S_READY;
      S_READY:    if (start_init)  state_d = S_INIT_ROW;
      default:                     state_d = S_IDLE;
    endcase
  end

  // A restart in READY takes the write port over a same-cycle insert.
  always_comb begin
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = 1'b0;
    row_end_d = 1'b0;
    err_d     = err_q;
    if (step) begin
      we_d      = 1'b1;
      addr_d    = seq_addr;
      data_d    = seq_data;
      last_d    = seq_last;
      row_end_d = seq_row_end;
    end else if (accept) begin
      if (in_range) begin
        we_d   = 1'b1;
        addr_d = ins_addr;
        data_d = ins_score;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      row_end_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      row_end_q <= row_end_d;
      err_q     <= err_d;
    end
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign err       = err_q;
  assign busy      = in_init;
  assign init_done = (state_q == S_READY);
  assign ins_ready = init_done;

endmodule
